// File: rtl/frame_bank_if.sv
// Handshake/bus bundle between frame-done logic, DDR address generators and frame_bank_manager.
interface frame_bank_if #(
  parameter int BANK_W = 3,
  parameter int CNT_W  = 16
);
  logic              frame_write_done;
  logic              frame_read_done;
  logic              wr_busy;
  logic              rd_busy;
  logic [BANK_W-1:0] wr_bank;
  logic [BANK_W-1:0] rd_bank;
  logic              wr_load;
  logic              rd_load;
  logic              wr_stall;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  repeat_cnt;

  modport master (
    output frame_write_done, frame_read_done, wr_busy, rd_busy,
    input  wr_bank, rd_bank, wr_load, rd_load, wr_stall, drop_cnt, repeat_cnt
  );

  modport slave (
    input  frame_write_done, frame_read_done, wr_busy, rd_busy,
    output wr_bank, rd_bank, wr_load, rd_load, wr_stall, drop_cnt, repeat_cnt
  );
endinterface

// File: rtl/frame_bank_manager.sv
// N-bank frame buffer manager: writer/reader bank allocation, reader always takes newest frame.
// Define FRAME_STATS_EN to build the drop/repeat statistics counters (otherwise driven 0).
module frame_bank_manager #(
  parameter int NUM_BANKS = 3,
  parameter int BANK_W    = 3,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_bank_if.slave   bus
);
  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_WRITING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  logic [NUM_BANKS-1:0][1:0] state_reg, state_next;
  logic [BANK_W-1:0] wr_bank_reg, wr_bank_next, rd_bank_reg, rd_bank_next;
  logic wr_load_reg, wr_load_next, rd_load_reg, rd_load_next;
  logic wr_stall_reg, wr_stall_next;
  logic started_reg;
  logic wr_done_q, wr_done_q2, rd_done_q, rd_done_q2;
  logic wr_pend_reg, rd_pend_reg;
  logic wr_service, rd_service, drop_inc, repeat_inc;
  logic ready_found, free_found;
  logic [BANK_W-1:0] ready_idx, free_idx;

  // A stalled writer has no bank of its own, so its pending done waits for the stall to clear.
  assign wr_service = wr_pend_reg & ~bus.wr_busy & ~wr_stall_reg;
  assign rd_service = rd_pend_reg & ~bus.rd_busy;

  always_comb begin
    state_next    = state_reg;
    wr_bank_next  = wr_bank_reg;
    rd_bank_next  = rd_bank_reg;
    wr_stall_next = wr_stall_reg;
    wr_load_next  = ~started_reg;
    rd_load_next  = ~started_reg;
    drop_inc      = 1'b0;
    repeat_inc    = 1'b0;
    ready_found   = 1'b0;
    ready_idx     = '0;
    free_found    = 1'b0;
    free_idx      = '0;

    if (wr_service) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (state_next[i] == ST_READY) begin
          state_next[i] = ST_FREE;
          drop_inc      = 1'b1;
        end
        if (BANK_W'(i) == wr_bank_reg)
          state_next[i] = ST_READY;
      end
      wr_stall_next = 1'b1;
    end

    // Read is resolved after write so it sees a frame completed on this same edge.
    if (rd_service) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (state_next[i] == ST_READY) begin
          ready_found = 1'b1;
          ready_idx   = BANK_W'(i);
        end
      end
      if (ready_found) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (BANK_W'(i) == rd_bank_reg)
            state_next[i] = ST_FREE;
          else if (BANK_W'(i) == ready_idx)
            state_next[i] = ST_READING;
        end
        rd_bank_next = ready_idx;
      end else begin
        repeat_inc = 1'b1;
      end
      rd_load_next = 1'b1;
    end

    // Writer needs a new bank: claim the lowest FREE one, including one freed just above.
    if (wr_stall_next) begin
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
        if (state_next[i] == ST_FREE) begin
          free_found = 1'b1;
          free_idx   = BANK_W'(i);
        end
      end
      if (free_found) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (BANK_W'(i) == free_idx)
            state_next[i] = ST_WRITING;
        end
        wr_bank_next  = free_idx;
        wr_stall_next = 1'b0;
        wr_load_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++)
        state_reg[i] <= (i == 0) ? ST_WRITING : ((i == NUM_BANKS - 1) ? ST_READING : ST_FREE);
      wr_bank_reg  <= '0;
      rd_bank_reg  <= BANK_W'(NUM_BANKS - 1);
      wr_load_reg  <= 1'b0;
      rd_load_reg  <= 1'b0;
      wr_stall_reg <= 1'b0;
      started_reg  <= 1'b0;
      wr_done_q    <= 1'b0;
      wr_done_q2   <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_done_q2   <= 1'b0;
      wr_pend_reg  <= 1'b0;
      rd_pend_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_bank_reg  <= wr_bank_next;
      rd_bank_reg  <= rd_bank_next;
      wr_load_reg  <= wr_load_next;
      rd_load_reg  <= rd_load_next;
      wr_stall_reg <= wr_stall_next;
      started_reg  <= 1'b1;
      wr_done_q    <= bus.frame_write_done;
      wr_done_q2   <= wr_done_q;
      rd_done_q    <= bus.frame_read_done;
      rd_done_q2   <= rd_done_q;
      // A rise while already pending merges into the existing request.
      wr_pend_reg  <= (wr_done_q & ~wr_done_q2) | (wr_pend_reg & ~wr_service);
      rd_pend_reg  <= (rd_done_q & ~rd_done_q2) | (rd_pend_reg & ~rd_service);
    end
  end

  assign bus.wr_bank  = wr_bank_reg;
  assign bus.rd_bank  = rd_bank_reg;
  assign bus.wr_load  = wr_load_reg;
  assign bus.rd_load  = rd_load_reg;
  assign bus.wr_stall = wr_stall_reg;

`ifdef FRAME_STATS_EN
  logic [CNT_W-1:0] drop_cnt_reg, repeat_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg   <= '0;
      repeat_cnt_reg <= '0;
    end else begin
      if (drop_inc && (drop_cnt_reg != '1))
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      if (repeat_inc && (repeat_cnt_reg != '1))
        repeat_cnt_reg <= repeat_cnt_reg + 1'b1;
    end
  end

  assign bus.drop_cnt   = drop_cnt_reg;
  assign bus.repeat_cnt = repeat_cnt_reg;
`else
  logic unused_stats;
  assign unused_stats   = drop_inc ^ repeat_inc;
  assign bus.drop_cnt   = '0;
  assign bus.repeat_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_bank_manager.sv
// Directed bench: 3-bank and 2-bank (narrow counters) managers driven from shared done/busy lines.
module tb_frame_bank_manager;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wd = 1'b0, rdn = 1'b0, wb = 1'b0, rb = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int wl3 = 0, rl3 = 0, wl2 = 0, rl2 = 0;
  int wl_snap, rl_snap;

`ifdef FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  frame_bank_if #(.BANK_W(3), .CNT_W(16)) bus3 ();
  frame_bank_if #(.BANK_W(3), .CNT_W(2))  bus2 ();

  assign bus3.frame_write_done = wd;
  assign bus3.frame_read_done  = rdn;
  assign bus3.wr_busy          = wb;
  assign bus3.rd_busy          = rb;
  assign bus2.frame_write_done = wd;
  assign bus2.frame_read_done  = rdn;
  assign bus2.wr_busy          = wb;
  assign bus2.rd_busy          = rb;

  frame_bank_manager #(.NUM_BANKS(3), .BANK_W(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );
  frame_bank_manager #(.NUM_BANKS(2), .BANK_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always @(negedge clk) begin
    if (bus3.wr_load) wl3++;
    if (bus3.rd_load) rl3++;
    if (bus2.wr_load) wl2++;
    if (bus2.rd_load) rl2++;
  end

  function automatic logic [31:0] stat(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic snap3();
    wl_snap = wl3;
    rl_snap = rl3;
  endtask

  task automatic pulse_write();
    @(negedge clk) wd = 1'b1;
    @(negedge clk) wd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk) rdn = 1'b1;
    @(negedge clk) rdn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_wr_bank", 32'(bus3.wr_bank), 32'd0);
    check_eq("rst_rd_bank", 32'(bus3.rd_bank), 32'd2);
    check_eq("rst_loads", 32'({bus3.wr_load, bus3.rd_load, bus3.wr_stall}), 32'd0);
    check_eq("rst_counters", 32'(bus3.drop_cnt) + 32'(bus3.repeat_cnt), 32'd0);
    check_eq("rst_rd_bank_n2", 32'(bus2.rd_bank), 32'd1);

    // Startup pulse
    snap3();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("startup_wr_load", 32'(wl3 - wl_snap), 32'd1);
    check_eq("startup_rd_load", 32'(rl3 - rl_snap), 32'd1);

    // Write done, with exact 2-clock latency
    snap3();
    @(negedge clk) wd = 1'b1;
    @(negedge clk) wd = 1'b0;
    @(negedge clk);
    check_eq("wr_latency_hold", 32'(bus3.wr_bank), 32'd0);
    @(negedge clk);
    check_eq("wr1_wr_bank", 32'(bus3.wr_bank), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("wr1_wr_load", 32'(wl3 - wl_snap), 32'd1);

    snap3();
    pulse_read();
    check_eq("rd1_rd_bank", 32'(bus3.rd_bank), 32'd0);
    check_eq("rd1_rd_load", 32'(rl3 - rl_snap), 32'd1);
    check_eq("rd1_no_stats", 32'(bus3.drop_cnt) + 32'(bus3.repeat_cnt), 32'd0);

    // b0 READING, b1 WRITING, b2 FREE: two writes, second drops the first
    pulse_write();
    check_eq("wr2_wr_bank", 32'(bus3.wr_bank), 32'd2);
    pulse_write();
    check_eq("wr3_wr_bank", 32'(bus3.wr_bank), 32'd1);
    check_eq("wr3_drop", 32'(bus3.drop_cnt), stat(32'd1));
    pulse_read();
    check_eq("rd2_newest", 32'(bus3.rd_bank), 32'd2);
    check_eq("rd2_no_repeat", 32'(bus3.repeat_cnt), 32'd0);

    // No READY bank: repeat
    snap3();
    pulse_read();
    check_eq("rep_rd_bank", 32'(bus3.rd_bank), 32'd2);
    check_eq("rep_rd_load", 32'(rl3 - rl_snap), 32'd1);
    check_eq("rep_cnt", 32'(bus3.repeat_cnt), stat(32'd1));

    // Simultaneous dones, writer busy 3 cycles
    snap3();
    @(negedge clk) begin wd = 1'b1; rdn = 1'b1; wb = 1'b1; end
    @(negedge clk) begin wd = 1'b0; rdn = 1'b0; end
    @(negedge clk);
    @(negedge clk);
    check_eq("sim_rd_repeat", 32'(bus3.repeat_cnt), stat(32'd2));
    check_eq("sim_rd_bank", 32'(bus3.rd_bank), 32'd2);
    check_eq("sim_wr_deferred", 32'(bus3.wr_bank), 32'd1);
    wb = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("sim_wr_after_busy", 32'(bus3.wr_bank), 32'd0);
    check_eq("sim_drop_same", 32'(bus3.drop_cnt), stat(32'd1));
    pulse_read();
    check_eq("sim_rd_takes", 32'(bus3.rd_bank), 32'd1);

    // b0 WRITING, b1 READING, b2 FREE: two rises while busy merge into one
    @(negedge clk) wb = 1'b1;
    pulse_write();
    pulse_write();
    @(negedge clk) wb = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("absorb_wr_bank", 32'(bus3.wr_bank), 32'd2);
    check_eq("absorb_drop", 32'(bus3.drop_cnt), stat(32'd1));

    // Mid-run reset
    do_reset();
    check_eq("mid_rst_wr", 32'(bus3.wr_bank), 32'd0);
    check_eq("mid_rst_rd", 32'(bus3.rd_bank), 32'd2);
    check_eq("mid_rst_cnt", 32'(bus3.drop_cnt) + 32'(bus3.repeat_cnt), 32'd0);

    // Two-bank manager: stall and same-edge reclaim
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wl_snap = wl2;
    pulse_write();
    check_eq("n2_stall", 32'(bus2.wr_stall), 32'd1);
    check_eq("n2_wr_hold", 32'(bus2.wr_bank), 32'd0);
    check_eq("n2_no_wr_load", 32'(wl2 - wl_snap), 32'd0);
    wl_snap = wl2;
    pulse_read();
    check_eq("n2_rd_bank", 32'(bus2.rd_bank), 32'd0);
    check_eq("n2_wr_bank", 32'(bus2.wr_bank), 32'd1);
    check_eq("n2_unstall", 32'(bus2.wr_stall), 32'd0);
    check_eq("n2_wr_load", 32'(wl2 - wl_snap), 32'd1);
    check_eq("n3_never_stall", 32'(bus3.wr_stall), 32'd0);

    // 2-bit repeat counter saturates at 3
    rl_snap = rl2;
    for (int k = 0; k < 4; k++) pulse_read();
    check_eq("n2_rd_loads", 32'(rl2 - rl_snap), 32'd4);
    check_eq("n2_repeat_sat", 32'(bus2.repeat_cnt), stat(32'd3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
